// File: rtl/noise_pkg.sv
// Shared constants and types for the noise trigger path: sound-latch bit map
// and default LFSR / timing parameters.
package noise_pkg;

  localparam int SND_BIT_EXPLO  = 0;
  localparam int SND_BIT_SHELL  = 1;
  localparam int SND_BIT_MASTER = 5;

  localparam int DIV_RATIO_DEF     = 256;
  localparam int LFSR_WIDTH_DEF    = 17;
  localparam int TAP_A_DEF         = 16;
  localparam int TAP_B_DEF         = 13;
  localparam int ONESHOT_TICKS_DEF = 3000;

  typedef logic [16:0] lfsr_t;

  localparam lfsr_t SEED_DEF = 17'h00001;

endpackage

// File: rtl/noise_lfsr.sv
// Divider, maximal-length LFSR with lock-up guard, and the MSB rising-edge
// strobe that clocks the downstream noise flip-flop.
module noise_lfsr
  import noise_pkg::*;
#(
  parameter int                    DIV_RATIO  = DIV_RATIO_DEF,
  parameter int                    LFSR_WIDTH = LFSR_WIDTH_DEF,
  parameter int                    TAP_A      = TAP_A_DEF,
  parameter int                    TAP_B      = TAP_B_DEF,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(SEED_DEF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en_i,
  output logic                  noise_clk_en_o,
  output logic [LFSR_WIDTH-1:0] lfsr_state_o
);

  localparam int            DW       = $clog2(DIV_RATIO);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);

  logic [DW-1:0]         div_q, div_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                  strobe_q, strobe_d;
  logic                  shift_tick;

  assign shift_tick = clk_en_i && (div_q == DIV_LAST);

  always_comb begin
    div_d    = div_q;
    lfsr_d   = lfsr_q;
    strobe_d = 1'b0;
    if (clk_en_i) begin
      div_d = shift_tick ? '0 : div_q + DW'(1);
    end
    if (shift_tick) begin
      // An all-zero register would never leave zero; reload the seed instead.
      if (lfsr_q == '0) begin
        lfsr_d = SEED;
      end else begin
        lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], lfsr_q[TAP_A] ^ lfsr_q[TAP_B]};
      end
      strobe_d = lfsr_d[LFSR_WIDTH-1] & ~lfsr_q[LFSR_WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      lfsr_q   <= SEED;
      strobe_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      lfsr_q   <= lfsr_d;
      strobe_q <= strobe_d;
    end
  end

  assign noise_clk_en_o = strobe_q;
  assign lfsr_state_o   = lfsr_q;

endmodule

// File: rtl/noise_trigger_gen.sv
// Noise path front end: pseudo-random clock-enable strobe plus sound-latch
// decode into a one-shot noise gate and loud/soft select.
module noise_trigger_gen
  import noise_pkg::*;
#(
  parameter int                    DIV_RATIO     = DIV_RATIO_DEF,
  parameter int                    LFSR_WIDTH    = LFSR_WIDTH_DEF,
  parameter int                    TAP_A         = TAP_A_DEF,
  parameter int                    TAP_B         = TAP_B_DEF,
  parameter logic [LFSR_WIDTH-1:0] SEED          = LFSR_WIDTH'(SEED_DEF),
  parameter int                    ONESHOT_TICKS = ONESHOT_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_3MHz_en,
  input  logic                  sound_wr,
  input  logic [7:0]            sound_data,
  output logic                  noise_clk_en,
  output logic                  noise_en,
  output logic                  loud_soft,
  output logic [LFSR_WIDTH-1:0] lfsr_state
);

  localparam int            TW         = $clog2(ONESHOT_TICKS + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ONESHOT_TICKS);

  logic [TW-1:0] timer_q, timer_d;
  logic          noise_en_q, noise_en_d;
  logic          loud_soft_q, loud_soft_d;
  logic          master_en_q, master_en_d;
  logic          unused_sound_bits;

  assign unused_sound_bits = ^{sound_data[7:6], sound_data[4:2]};

  noise_lfsr #(
    .DIV_RATIO  (DIV_RATIO),
    .LFSR_WIDTH (LFSR_WIDTH),
    .TAP_A      (TAP_A),
    .TAP_B      (TAP_B),
    .SEED       (SEED)
  ) u_lfsr (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_en_i       (clk_3MHz_en),
    .noise_clk_en_o (noise_clk_en),
    .lfsr_state_o   (lfsr_state)
  );

  always_comb begin
    timer_d     = timer_q;
    noise_en_d  = noise_en_q;
    loud_soft_d = loud_soft_q;
    master_en_d = master_en_q;
    if (clk_3MHz_en && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
      if (timer_q == TW'(1)) begin
        noise_en_d = 1'b0;
      end
    end
    // A CPU write overrides any decrement in the same cycle.
    if (sound_wr) begin
      master_en_d = sound_data[SND_BIT_MASTER];
      if (!sound_data[SND_BIT_MASTER]) begin
        timer_d    = '0;
        noise_en_d = 1'b0;
      end else if (sound_data[SND_BIT_EXPLO]) begin
        loud_soft_d = 1'b1;
        timer_d     = TIMER_LOAD;
        noise_en_d  = 1'b1;
      end else if (sound_data[SND_BIT_SHELL]) begin
        loud_soft_d = 1'b0;
        timer_d     = TIMER_LOAD;
        noise_en_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q     <= '0;
      noise_en_q  <= 1'b0;
      loud_soft_q <= 1'b0;
      master_en_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      noise_en_q  <= noise_en_d;
      loud_soft_q <= loud_soft_d;
      master_en_q <= master_en_d;
    end
  end

  assign noise_en  = noise_en_q;
  assign loud_soft = loud_soft_q;

endmodule

// File: tb/tb_noise_trigger_gen.sv
// Self-checking bench for noise_trigger_gen: default build for trigger/timer
// behaviour, a fast-divider build against an LFSR model, and a zero-seed build.
module tb_noise_trigger_gen;
  import noise_pkg::*;

  localparam int NSHIFT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Build A: default parameters.
  logic        rst_a = 1'b0, en_a = 1'b0, wr_a = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic        strobe_a, ne_a, ls_a;
  logic [16:0] lfsr_a;

  // Builds B (fast divider) and C (zero seed) share reset and stimulus.
  logic        rst_b = 1'b0, en_b = 1'b1, wr_b = 1'b0;
  logic [7:0]  data_b = 8'h00;
  logic        strobe_b, ne_b, ls_b, strobe_c, ne_c, ls_c;
  logic [16:0] lfsr_b, lfsr_c;

  noise_trigger_gen dut_a (
    .clk(clk), .reset_n(rst_a), .clk_3MHz_en(en_a), .sound_wr(wr_a),
    .sound_data(data_a), .noise_clk_en(strobe_a), .noise_en(ne_a),
    .loud_soft(ls_a), .lfsr_state(lfsr_a));

  noise_trigger_gen #(.DIV_RATIO(2)) dut_b (
    .clk(clk), .reset_n(rst_b), .clk_3MHz_en(en_b), .sound_wr(wr_b),
    .sound_data(data_b), .noise_clk_en(strobe_b), .noise_en(ne_b),
    .loud_soft(ls_b), .lfsr_state(lfsr_b));

  noise_trigger_gen #(.DIV_RATIO(2), .SEED(17'h00000)) dut_c (
    .clk(clk), .reset_n(rst_b), .clk_3MHz_en(en_b), .sound_wr(wr_b),
    .sound_data(data_b), .noise_clk_en(strobe_c), .noise_en(ne_c),
    .loud_soft(ls_c), .lfsr_state(lfsr_c));

  int n_checks = 0;
  int n_fail   = 0;
  bit done_b   = 1'b0;

  typedef struct {
    string nm;
    logic  ne;
    logic  ls;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       ne;
    logic       ls;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of build A stimulus, from negedge to the following negedge.
  task automatic cyc(input logic en, input logic wr, input logic [7:0] d);
    en_a = en; wr_a = wr; data_a = d;
    @(posedge clk); @(negedge clk);
    en_a = 1'b0; wr_a = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.nm, " noise_en"}, ne_a, e.ne);
      chk({e.nm, " loud_soft"}, ls_a, e.ls);
    end
  endtask

  task automatic wr(input string nm, input logic [7:0] d, input logic en,
                    input logic ne, input logic ls);
    exp_t e;
    e.nm = nm; e.ne = ne; e.ls = ls;
    sb_q.push_back(e);
    cyc(en, 1'b1, d);
    sb_check();
  endtask

  task automatic setv(input int i, input logic [7:0] d, input logic ne, input logic ls);
    vecs[i].data = d; vecs[i].ne = ne; vecs[i].ls = ls;
  endtask

  // Build A: reset, first shift, sound-latch decode, timer and async reset.
  initial begin
    setv(0,  8'h00, 1'b0, 1'b0);
    setv(1,  8'h20, 1'b0, 1'b0);
    setv(2,  8'h22, 1'b1, 1'b0);
    setv(3,  8'h21, 1'b1, 1'b1);
    setv(4,  8'h20, 1'b1, 1'b1);
    setv(5,  8'h23, 1'b1, 1'b1);
    setv(6,  8'h22, 1'b1, 1'b0);
    setv(7,  8'h02, 1'b0, 1'b0);
    setv(8,  8'h23, 1'b1, 1'b1);
    setv(9,  8'h01, 1'b0, 1'b1);
    setv(10, 8'h01, 1'b0, 1'b1);
    setv(11, 8'hDC, 1'b0, 1'b1);
    setv(12, 8'hE1, 1'b1, 1'b1);
    setv(13, 8'h1E, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("reset noise_en", ne_a, 1'b0);
    chk("reset loud_soft", ls_a, 1'b0);
    chk("reset noise_clk_en", strobe_a, 1'b0);
    chk("reset lfsr", lfsr_a, 17'h00001);
    rst_a = 1'b1;

    for (int i = 0; i < 255; i++) begin
      tick_n(1);
      chk("pre-shift strobe", strobe_a, 1'b0);
    end
    chk("lfsr before 256th tick", lfsr_a, 17'h00001);
    tick_n(1);
    chk("lfsr after 256th tick", lfsr_a, 17'h00002);
    chk("first shift strobe", strobe_a, 1'b0);

    for (int i = 0; i < 14; i++) begin
      wr($sformatf("vec%0d", i), vecs[i].data, 1'b0, vecs[i].ne, vecs[i].ls);
    end

    wr("loud start", 8'h21, 1'b0, 1'b1, 1'b1);
    tick_n(2999);
    chk("loud 2999 noise_en", ne_a, 1'b1);
    tick_n(1);
    chk("loud 3000 noise_en", ne_a, 1'b0);
    chk("loud 3000 loud_soft", ls_a, 1'b1);

    // Retrigger lands in the same cycle as a decrement; reload must win.
    wr("loud again", 8'h21, 1'b0, 1'b1, 1'b1);
    tick_n(2000);
    chk("loud 2000 noise_en", ne_a, 1'b1);
    wr("shell retrig", 8'h22, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00);
    tick_n(2999);
    chk("retrig 2999 noise_en", ne_a, 1'b1);
    tick_n(1);
    chk("retrig 3000 noise_en", ne_a, 1'b0);
    chk("retrig 3000 loud_soft", ls_a, 1'b0);

    wr("both bits", 8'h23, 1'b0, 1'b1, 1'b1);
    wr("master off", 8'h01, 1'b0, 1'b0, 1'b1);
    tick_n(5);
    wr("off trigger", 8'h01, 1'b1, 1'b0, 1'b1);
    tick_n(3);
    chk("off stays quiet", ne_a, 1'b0);

    wr("pre-reset", 8'h21, 1'b0, 1'b1, 1'b1);
    tick_n(300);
    #2 rst_a = 1'b0;
    #1;
    chk("async noise_en", ne_a, 1'b0);
    chk("async loud_soft", ls_a, 1'b0);
    chk("async noise_clk_en", strobe_a, 1'b0);
    chk("async lfsr", lfsr_a, 17'h00001);
    @(negedge clk);
    rst_a = 1'b1;

    for (int i = 0; i < 100000 && !done_b; i++) @(negedge clk);
    if (!done_b) chk("build B timeout", 32'd1, 32'd0);
    if (sb_q.size() != 0) chk("scoreboard leftover", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Builds B and C: every-cycle enable, shift_tick every second clock.
  initial begin
    lfsr_t m, prev;
    logic  exp_s, msb_prev;
    int    rises, pulses;
    m = 17'h00001; rises = 0; pulses = 0; msb_prev = 1'b0;
    repeat (3) @(negedge clk);
    chk("B reset lfsr", lfsr_b, 17'h00001);
    chk("C reset lfsr", lfsr_c, 17'h00000);
    rst_b = 1'b1;
    for (int k = 0; k < NSHIFT; k++) begin
      @(posedge clk); @(negedge clk);
      chk("B idle strobe", strobe_b, 1'b0);
      chk("B idle lfsr", lfsr_b, m);
      @(posedge clk); @(negedge clk);
      prev  = m;
      m     = (m == '0) ? 17'h00001 : {m[15:0], m[16] ^ m[13]};
      exp_s = m[16] & ~prev[16];
      chk($sformatf("B lfsr shift %0d", k), lfsr_b, m);
      chk($sformatf("B strobe shift %0d", k), strobe_b, exp_s);
      if (lfsr_b[16] && !msb_prev) rises++;
      msb_prev = lfsr_b[16];
      if (strobe_b) pulses++;
      if (k < 4) begin
        chk("C zero-seed lfsr", lfsr_c, 17'h00000);
        chk("C zero-seed strobe", strobe_c, 1'b0);
      end
    end
    chk("B pulses vs MSB rises", pulses, rises);
    done_b = 1'b1;
  end

endmodule

// File: doc/noise_trigger_gen.md
Name: noise_trigger_gen

Overview:
- Upstream stage of the noise sound path. Generates the pseudo-random clock-enable strobe that toggles the noise flip-flop.
- Also turns CPU sound-latch writes into the noise_en / loud_soft controls for the explosion and shell sounds.
- Outputs feed directly into the noise amplitude/filter stage.
- Runs from the system clock, gated by the 3 MHz enable.

Parameters:
- DIV_RATIO, 256: number of clk_3MHz_en ticks per LFSR shift (about 11.7 kHz).
- LFSR_WIDTH, 17: shift register length.
- TAP_A, 16: first feedback tap index.
- TAP_B, 13: second feedback tap index (polynomial x^17+x^14+1).
- SEED, 17'h00001: LFSR reset and lock-up reload value; must be non-zero.
- ONESHOT_TICKS, 3000: noise_en hold time after a trigger, in clk_3MHz_en ticks (about 1 ms).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- clk_3MHz_en, in, 1: one-cycle enable at 3 MHz.
- sound_wr, in, 1: one-cycle strobe; sound_data is valid in this cycle.
- sound_data, in, 8: bit0 = explosion trigger (loud), bit1 = shell trigger (soft), bit5 = master sound enable; other bits ignored.
- noise_clk_en, out, 1: one-cycle strobe to the noise flip-flop.
- noise_en, out, 1: noise gate; level signal.
- loud_soft, out, 1: 1 = loud, 0 = soft.
- lfsr_state, out, LFSR_WIDTH: current LFSR contents, for debug and verification.

Behaviour:
- Reset (asynchronous, reset_n=0): divider=0, lfsr=SEED, timer=0, master_en=0. All outputs are 0 except lfsr_state=SEED. Reset mid-sound drops noise_en immediately.
- Divider:
  - Counter of width $clog2(DIV_RATIO), advancing only on clk_3MHz_en.
  - When it equals DIV_RATIO-1 on a clk_3MHz_en cycle it wraps to 0 and asserts internal shift_tick for that cycle.
  - The first shift_tick after reset occurs on the DIV_RATIO-th clk_3MHz_en.
- LFSR:
  - On shift_tick: lfsr <= {lfsr[W-2:0], lfsr[TAP_A]^lfsr[TAP_B]}.
  - If lfsr is all-zero at a shift_tick, load SEED instead (lock-up guard).
  - lfsr_state is the register itself.
- noise_clk_en:
  - Registered. High for exactly one clk cycle, on the cycle after a shift_tick in which the new lfsr[W-1] is 1 and the old lfsr[W-1] was 0 (rising edge of the LFSR MSB).
  - Never high on two consecutive cycles.
- master_en: updated from sound_data[5] on every sound_wr.
- Trigger handling, on sound_wr:
  - sound_data[5]=0: master_en<=0, noise_en<=0, timer<=0 on the next edge. Trigger bits are ignored.
  - sound_data[5]=1 and bit0=1: loud_soft<=1, timer<=ONESHOT_TICKS, noise_en<=1.
  - sound_data[5]=1, bit0=0, bit1=1: loud_soft<=0, timer<=ONESHOT_TICKS, noise_en<=1.
  - bit0 and bit1 both set: loud wins.
  - Retrigger while active reloads the timer; loud_soft takes the new value.
  - No trigger bits set: timer and noise_en are unchanged; only master_en updates.
- Timer:
  - Decrements on clk_3MHz_en when non-zero.
  - On the edge where it goes 1->0, noise_en<=0.
  - A sound_wr in the same cycle as a decrement takes priority; the reload wins.
- loud_soft holds its last value after noise_en falls. The downstream decay uses it.
- Latency: noise_en / loud_soft change on the clk edge after sound_wr (1 cycle). noise_clk_en comes 1 cycle after shift_tick.
- LFSR and divider run continuously regardless of master_en; only the gate is controlled.

Decomposition:
- Package noise_pkg:
  - Bit-position constants SND_BIT_EXPLO=0, SND_BIT_SHELL=1, SND_BIT_MASTER=5.
  - Default LFSR constants.
  - Typedef lfsr_t (logic [16:0]).
- One sub-module, noise_lfsr: divider, LFSR, lock-up guard and edge strobe; outputs noise_clk_en and lfsr_state.
- Trigger and timer logic stay in the top.

Test Plan:
- Reset, then 256 clk_3MHz_en pulses -> exactly one shift. lfsr_state 17'h00001 -> 17'h00002. noise_clk_en stays 0 (MSB 0->0).
- Run 2^17-1 shift_ticks from SEED -> lfsr_state returns to 17'h00001 with no earlier repeat. Count of noise_clk_en pulses equals the count of MSB 0->1 transitions (reference-model compare).
- sound_wr data=8'h21 -> next cycle noise_en=1, loud_soft=1. After exactly 3000 clk_3MHz_en, noise_en=0 and loud_soft stays 1.
- data=8'h22 at tick 2000 of an active loud sound -> loud_soft=0, timer reloaded. noise_en falls 3000 ticks after the second write.
- data=8'h23 -> loud_soft=1. Then data=8'h01 (master off) -> noise_en=0 next cycle. A later data=8'h01 with master off produces no trigger.
- Assert reset_n=0 asynchronously mid-sound (between clk edges) -> noise_en, loud_soft and noise_clk_en go 0 immediately, lfsr_state=17'h00001. Force an all-zero LFSR via a bench SEED=0 build -> it reloads 0 at the tick (guard documented as SEED-dependent).
